// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXI-Stream FIFO.
// Holds the address-width function used by the top level and the RAM.
package axis_fifo_pkg;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM with synchronous read, shaped for block-RAM inference.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_re/i_raddr/o_rdata read port.
import axis_fifo_pkg::*;

module axis_fifo_ram #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 4096,
    parameter int unsigned AddrW = addr_width(Depth)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AddrW-1:0] i_waddr,
    input  logic [Width-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AddrW-1:0] i_raddr,
    output logic [Width-1:0] o_rdata
);

    logic [Width-1:0] r_mem [Depth];
    logic [Width-1:0] r_rdata;

    // The read register only loads on i_re, so it holds the presented
    // beat while the consumer stalls.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO carrying {last, data} per beat.
// Ports: clk, reset (async, active high); slave writeData/Valid/Ready/Last;
// master readData/Valid/Ready/Last.
import axis_fifo_pkg::*;

module axis_fifo #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DataWidth-1:0] writeData,
    input  logic                 writeDataValid,
    output logic                 writeDataReady,
    input  logic                 writeDataLast,
    output logic [DataWidth-1:0] readData,
    output logic                 readDataValid,
    input  logic                 readDataReady,
    output logic                 readDataLast
);

    localparam int unsigned AW = addr_width(Depth);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic                 last;
        logic [DataWidth-1:0] data;
    } entry_t;

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ready;
    logic          r_valid;
    logic          r_seen;

    logic          w_wr;
    logic          w_pop;
    logic          w_rd;
    logic [CW-1:0] w_ram_cnt;
    logic [CW-1:0] w_count_nxt;
    entry_t        w_wentry;
    entry_t        w_rentry;

    assign w_wr  = writeDataValid && r_ready;
    assign w_pop = r_valid && readDataReady;

    // Beats still in RAM: everything counted minus the one presented.
    assign w_ram_cnt = r_count - CW'(r_valid);

    // Fetch into the output register whenever it is empty or draining.
    // A fetch needs w_ram_cnt > 0, so rptr != wptr while a write is
    // possible: the RAM never sees read and write on one address.
    assign w_rd = (w_ram_cnt != '0) && (!r_valid || readDataReady);

    assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);

    assign w_wentry.last = writeDataLast;
    assign w_wentry.data = writeData;

    axis_fifo_ram #(
        .Width (DataWidth + 1),
        .Depth (Depth),
        .AddrW (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata (w_wentry),
        .i_re    (w_rd),
        .i_raddr (r_rptr),
        .o_rdata (w_rentry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_seen  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
                r_valid <= 1'b1;
                r_seen  <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            r_count <= w_count_nxt;
            // Registered full flag: a pop at full frees space next cycle.
            r_ready <= (w_count_nxt < CW'(Depth));
        end
    end

    // The RAM read register has no reset; r_seen masks stale contents
    // until the first fetch after reset.
    assign readData       = r_seen ? w_rentry.data : '0;
    assign readDataLast   = r_seen ? w_rentry.last : 1'b0;
    assign readDataValid  = r_valid;
    assign writeDataReady = r_ready;

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo.
// Scoreboard queue of {last, data} checked against beats leaving the FIFO.
module tb_axis_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] writeData;
    logic          writeDataValid;
    logic          writeDataReady;
    logic          writeDataLast;
    logic [DW-1:0] readData;
    logic          readDataValid;
    logic          readDataReady;
    logic          readDataLast;

    int vec  = 0;
    int miss = 0;
    logic [DW:0] sb [$];

    axis_fifo #(
        .DataWidth (DW),
        .Depth     (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .writeData      (writeData),
        .writeDataValid (writeDataValid),
        .writeDataReady (writeDataReady),
        .writeDataLast  (writeDataLast),
        .readData       (readData),
        .readDataValid  (readDataValid),
        .readDataReady  (readDataReady),
        .readDataLast   (readDataLast)
    );

    always #5 clk = ~clk;

    // One clock: drive at negedge, sample handshakes, then pass the edge.
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic l, input logic rr,
                        output logic acc, output logic pop,
                        output logic [DW:0] got);
        @(negedge clk);
        writeDataValid = v;
        writeData      = d;
        writeDataLast  = l;
        readDataReady  = rr;
        #1;
        acc = v && writeDataReady;
        pop = readDataValid && rr;
        got = {readDataLast, readData};
        if (acc) sb.push_back({l, d});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        writeDataValid = 1'b0;
        writeData = '0;
        writeDataLast = 1'b0;
        readDataReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vec++;
        if ({readDataValid, readDataLast, readData, writeDataReady} !== '0) begin
            miss++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h rdy=%b, required all 0",
                     readDataValid, readDataLast, readData, writeDataReady);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        vec++;
        if (writeDataReady !== 1'b1) begin
            miss++;
            $display("FAIL reset_ready: got %b, required 1", writeDataReady);
        end
        vec++;
        if (readDataValid !== 1'b0) begin
            miss++;
            $display("FAIL reset_valid: got %b, required 0", readDataValid);
        end
    endtask

    task automatic test_single();
        logic acc, pop;
        logic [DW:0] got, exp;
        step(1'b1, 32'h2, 1'b0, 1'b1, acc, pop, got);
        vec++;
        if (acc !== 1'b1 || readDataValid !== 1'b0) begin
            miss++;
            $display("FAIL single_accept: got acc=%b v=%b, required acc=1 v=0", acc, readDataValid);
        end
        step(1'b0, '0, 1'b0, 1'b1, acc, pop, got);
        vec++;
        if (readDataValid !== 1'b1 || readData !== 32'h2) begin
            miss++;
            $display("FAIL single_latency: got v=%b d=%h, required v=1 d=2", readDataValid, readData);
        end
        step(1'b0, '0, 1'b0, 1'b1, acc, pop, got);
        vec++;
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        if (pop !== 1'b1 || got !== exp) begin
            miss++;
            $display("FAIL single_data: got pop=%b %h, required pop=1 %h", pop, got, exp);
        end
        vec++;
        if (readDataValid !== 1'b0) begin
            miss++;
            $display("FAIL single_empty: got v=%b, required 0", readDataValid);
        end
    endtask

    task automatic test_backpressure();
        logic acc, pop;
        logic [DW:0] got, exp;
        step(1'b1, 32'h3, 1'b1, 1'b0, acc, pop, got);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, acc, pop, got);
            vec++;
            if (readDataValid !== 1'b1 || readData !== 32'h3 || readDataLast !== 1'b1) begin
                miss++;
                $display("FAIL bp_hold: got v=%b d=%h l=%b, required v=1 d=3 l=1",
                         readDataValid, readData, readDataLast);
            end
        end
        step(1'b0, '0, 1'b0, 1'b1, acc, pop, got);
        vec++;
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        if (pop !== 1'b1 || got !== exp) begin
            miss++;
            $display("FAIL bp_data: got pop=%b %h, required pop=1 %h", pop, got, exp);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, acc, pop, got);
            vec++;
            if (pop !== 1'b0) begin
                miss++;
                $display("FAIL bp_dup: got extra beat %h, required none", got);
            end
        end
    endtask

    task automatic test_stream();
        logic acc, pop, rr;
        logic [DW:0] got, exp;
        int wrote = 0;
        int cyc = 0;
        while ((wrote < 40 || sb.size() != 0) && cyc < 300) begin
            rr = !((cyc < 7) || (cyc >= 17 && cyc < 19));
            step(wrote < 40, $urandom(), (wrote % 4) == 3, rr, acc, pop, got);
            if (acc) wrote++;
            if (pop) begin
                vec++;
                exp = (sb.size() != 0) ? sb.pop_front() : 'x;
                if (got !== exp) begin
                    miss++;
                    $display("FAIL stream_data: got %h, required %h", got, exp);
                end
            end
            cyc++;
        end
        vec++;
        if (wrote < 40 || sb.size() != 0) begin
            miss++;
            $display("FAIL stream_timeout: got %0d written %0d pending, required 40 and 0",
                     wrote, sb.size());
        end
    endtask

    task automatic test_full();
        logic acc, pop;
        logic [DW:0] got, exp;
        int n = 0;
        int cyc = 0;
        while (n < DEPTH && cyc < DEPTH + 20) begin
            step(1'b1, $urandom(), n[0], 1'b0, acc, pop, got);
            if (acc) n++;
            cyc++;
        end
        vec++;
        if (n != DEPTH || writeDataReady !== 1'b0) begin
            miss++;
            $display("FAIL full_ready: got %0d accepts rdy=%b, required %0d rdy=0",
                     n, writeDataReady, DEPTH);
        end
        step(1'b1, 32'hDEAD, 1'b0, 1'b0, acc, pop, got);
        vec++;
        if (acc !== 1'b0) begin
            miss++;
            $display("FAIL full_overflow: got accept=%b, required 0", acc);
        end
        step(1'b0, '0, 1'b0, 1'b1, acc, pop, got);
        vec++;
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        if (pop !== 1'b1 || got !== exp) begin
            miss++;
            $display("FAIL full_pop: got pop=%b %h, required pop=1 %h", pop, got, exp);
        end
        vec++;
        if (writeDataReady !== 1'b1) begin
            miss++;
            $display("FAIL full_rearm: got %b, required 1", writeDataReady);
        end
        cyc = 0;
        while (sb.size() != 0 && cyc < DEPTH + 20) begin
            step(1'b0, '0, 1'b0, 1'b1, acc, pop, got);
            if (pop) begin
                vec++;
                exp = sb.pop_front();
                if (got !== exp) begin
                    miss++;
                    $display("FAIL full_drain: got %h, required %h", got, exp);
                end
            end
            cyc++;
        end
        vec++;
        if (sb.size() != 0 || readDataValid !== 1'b0) begin
            miss++;
            $display("FAIL full_drain_end: got %0d pending v=%b, required 0 v=0",
                     sb.size(), readDataValid);
        end
    endtask

    task automatic test_wrap();
        logic acc, pop;
        logic [DW:0] got, exp;
        int wrote = 0;
        int cyc = 0;
        while ((wrote < 3 * DEPTH || sb.size() != 0) && cyc < 9 * DEPTH) begin
            step(wrote < 3 * DEPTH, $urandom(), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, acc, pop, got);
            if (acc) wrote++;
            if (pop) begin
                vec++;
                exp = (sb.size() != 0) ? sb.pop_front() : 'x;
                if (got !== exp) begin
                    miss++;
                    $display("FAIL wrap_data: got %h, required %h", got, exp);
                end
            end
            cyc++;
        end
        vec++;
        if (wrote < 3 * DEPTH || sb.size() != 0) begin
            miss++;
            $display("FAIL wrap_timeout: got %0d written %0d pending, required %0d and 0",
                     wrote, sb.size(), 3 * DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, pop;
        logic [DW:0] got, exp;
        int n = 0;
        int cyc = 0;
        while (n < 100 && cyc < 200) begin
            step(1'b1, $urandom(), 1'b0, 1'b0, acc, pop, got);
            if (acc) n++;
            cyc++;
        end
        @(negedge clk);
        writeDataValid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        vec++;
        if (readDataValid !== 1'b0 || writeDataReady !== 1'b0 || readData !== '0) begin
            miss++;
            $display("FAIL midreset_async: got v=%b rdy=%b d=%h, required 0 0 0",
                     readDataValid, writeDataReady, readData);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, acc, pop, got);
            vec++;
            if (readDataValid !== 1'b0) begin
                miss++;
                $display("FAIL midreset_stale: got beat %h, required none", got);
            end
        end
        step(1'b1, 32'hABC, 1'b1, 1'b1, acc, pop, got);
        cyc = 0;
        while (sb.size() != 0 && cyc < 10) begin
            step(1'b0, '0, 1'b0, 1'b1, acc, pop, got);
            if (pop) begin
                vec++;
                exp = sb.pop_front();
                if (got !== exp) begin
                    miss++;
                    $display("FAIL midreset_new: got %h, required %h", got, exp);
                end
            end
            cyc++;
        end
        step(1'b0, '0, 1'b0, 1'b1, acc, pop, got);
        vec++;
        if (sb.size() != 0 || pop !== 1'b0 || readDataValid !== 1'b0) begin
            miss++;
            $display("FAIL midreset_end: got %0d pending pop=%b, required 0 0", sb.size(), pop);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_full();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
- Single-clock AXI-Stream FIFO carrying a data word plus a last flag per beat.
- Sits between an upstream stream producer (slave side, "write") and a downstream consumer (master side, "read").
- Absorbs back-pressure up to Depth words.
- Operates first-word-fall-through with a registered output stage; no packet (store-and-forward) semantics.

Parameters:
- DataWidth, 32: width of writeData/readData in bits.
- Depth, 4096: capacity in beats. Must be a power of two, ≥ 4.

Ports:
- clk, input, 1: rising-edge clock for all logic.
- reset, input, 1: asynchronous, active-high reset.
- writeData, input, DataWidth: slave tdata.
- writeDataValid, input, 1: slave tvalid.
- writeDataReady, output, 1: slave tready; high when the FIFO can accept a beat.
- writeDataLast, input, 1: slave tlast; stored alongside the data.
- readData, output, DataWidth: master tdata (head of FIFO).
- readDataValid, output, 1: master tvalid.
- readDataReady, input, 1: master tready.
- readDataLast, output, 1: master tlast of the head beat.

Behaviour:
- Reset (asynchronous assert, synchronous release on clk):
  - Pointers and occupancy count clear; stored contents are discarded.
  - readDataValid=0, readDataLast=0, readData=0, writeDataReady=0 while reset is high.
  - writeDataReady rises on the first clk edge after release.
- Write handshake: a beat is accepted on a rising edge where writeDataValid && writeDataReady. writeData and writeDataLast are captured together as one entry {last, data}.
- Read handshake: a beat is consumed on a rising edge where readDataValid && readDataReady. The next entry, if any, is presented in the following cycle with no bubble.
- Occupancy count covers every beat held (storage RAM, in-flight read, and output stage). Its width is clog2(Depth)+1.
- writeDataReady is registered and equals (count < Depth). It has no combinational path from any input.
- Full FIFO (count == Depth): writeDataReady=0. A read in the same cycle does not allow a same-cycle write; ready reasserts on the next cycle.
- Empty FIFO: readDataValid=0, and readData/readDataLast hold their last values.
- Latency: a beat accepted at edge N into an empty FIFO gives readDataValid=1 after edge N+1.
- Throughput: 1 beat/clock sustained when writeDataValid and readDataReady are held high.
- Simultaneous write and read: the count is unchanged. Both succeed at any non-full, non-empty level.
- Output stability: while readDataValid && !readDataReady, readData, readDataLast and readDataValid must not change.
- Ordering is strict FIFO. The last flag travels bit-exact with its data.
- Pointer wrap: the write and read address pointers are clog2(Depth) bits and wrap naturally from Depth-1 to 0.
- Storage:
  - Use a simple dual-port RAM with synchronous read, inferable as block RAM.
  - Any read-during-write to the same address must not corrupt returned data. Guarantee this by the prefetch/skid design: never read an address being written in the same cycle.
- Reset asserted mid-transfer aborts all state immediately; no beat is output afterwards until a new write.

Decomposition:
- Package axis_fifo_pkg holds:
  - a function computing address width, clog2(Depth);
  - a parameterised entry struct typedef {last, data}.
- Sub-module axis_fifo_ram: a simple dual-port synchronous-read RAM with Depth entries of DataWidth+1 bits.
- The top level contains the pointers, count, prefetch/skid output stage, and handshake logic.

Test Plan:
- Reset: hold reset high for 1 cycle, then release. Require all outputs 0 during reset, writeDataReady=1 one edge after release, and readDataValid=0.
- Single beat, both sides ready: write 0x2 with ready=1. readDataValid rises after the next edge with readData=0x2. It is consumed on the following edge and the FIFO returns to empty.
- Back-pressure:
  - With readDataReady=0, write 0x3 for one beat, then deassert valid for 3 cycles. readData must stay 0x3 with valid=1.
  - Then raise readDataReady: 0x3 is consumed exactly once and no duplicate appears.
- Packet stream with stalls:
  - Write continuous random beats with writeDataLast on every 4th beat.
  - Drop readDataReady for 7 cycles, raise it for 10, drop it for 2, then raise it.
  - Output order, data and last positions must match input exactly.
- Full boundary: with readDataReady=0, write Depth (4096) beats. writeDataReady falls after the 4096th accept, and a 4097th valid beat is not accepted. One read reasserts ready on the next cycle.
- Wrap and reset mid-operation:
  - Stream 3×Depth beats at 1/clk with random ready gaps; no loss or reorder across pointer wrap.
  - Assert reset while 100 beats are buffered: valid drops immediately and nothing old is output afterwards.
